// File: rtl/layer_pkg.sv
// Shared definitions for the per-output-channel layer sequencer:
// default geometry, counter width helper and FSM state encodings.
package layer_pkg;

    localparam int OC_DEF           = 15;
    localparam int LANES_DEF        = 8;
    localparam int LOAD_CYC_DEF     = 2;
    localparam int TREE_LAT_DEF     = 3;
    localparam int CONV_TIMEOUT_DEF = 4095;

    // Bits needed for a counter that runs 0..n-1 (never narrower than 1).
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Counter and index widths for the default geometry.
    localparam int LOADW = cnt_w(LOAD_CYC_DEF);
    localparam int TREEW = cnt_w(TREE_LAT_DEF);
    localparam int TOW   = cnt_w(CONV_TIMEOUT_DEF);
    localparam int CW    = cnt_w(OC_DEF);

    // 3-bit state encoding, kept as plain constants for legacy tools.
    typedef logic [2:0] state_t;
    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_LOAD  = 3'd1;
    localparam state_t S_CONV  = 3'd2;
    localparam state_t S_TREE  = 3'd3;
    localparam state_t S_STORE = 3'd4;
    localparam state_t S_POOL  = 3'd5;
    localparam state_t S_NEXT  = 3'd6;
    localparam state_t S_DONE  = 3'd7;

endpackage

// File: rtl/lane_done_tracker.sv
// Sticky per-lane completion mask for one convolution sweep.
// all_done looks through to the current lane_done so that the last
// lanes finishing in the same cycle complete the sweep immediately.
module lane_done_tracker
    import layer_pkg::*;
#(
    parameter int LANES = LANES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [LANES-1:0] lane_done,
    output logic [LANES-1:0] mask,
    output logic             all_done
);

    // Accumulate lane completions while enabled; clr empties the mask.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            mask <= '0;
        end else if (clr) begin
            mask <= '0;
        end else if (en) begin
            mask <= mask | lane_done;
        end
    end

    assign all_done = &(mask | lane_done);

endmodule

// File: rtl/layer_sequencer.sv
// Per-output-channel scheduler for the 8-lane convolution layer:
// load -> conv -> adder tree -> store -> pool, repeated for OC channels.
// All control outputs are flops loaded from the next state, so each one
// is high exactly while the FSM sits in the matching state.
module layer_sequencer
    import layer_pkg::*;
#(
    parameter int OC           = OC_DEF,
    parameter int LANES        = LANES_DEF,
    parameter int LOAD_CYC     = LOAD_CYC_DEF,
    parameter int TREE_LAT     = TREE_LAT_DEF,
    parameter int CONV_TIMEOUT = CONV_TIMEOUT_DEF,
    parameter int CW           = cnt_w(OC)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LANES-1:0] lane_done,
    input  logic             pool_done,
    output logic             c_load,
    output logic             conv,
    output logic             tree,
    output logic             store,
    output logic             pool,
    output logic [CW-1:0]    out_c,
    output logic             busy,
    output logic             cout_done,
    output logic             timeout_err
);

    localparam int LD_W = cnt_w(LOAD_CYC);
    localparam int TR_W = cnt_w(TREE_LAT);
    localparam int TO_W = cnt_w(CONV_TIMEOUT);

    localparam logic [LD_W-1:0] LOAD_LAST = LD_W'(LOAD_CYC - 1);
    localparam logic [TR_W-1:0] TREE_LAST = TR_W'(TREE_LAT - 1);
    localparam logic [TO_W-1:0] CONV_LAST = TO_W'(CONV_TIMEOUT - 1);
    localparam logic [CW-1:0]   CH_LAST   = CW'(OC - 1);

    state_t            state;
    state_t            state_nx;
    logic [LD_W-1:0]   load_cnt;
    logic [TR_W-1:0]   tree_cnt;
    logic [TO_W-1:0]   conv_cnt;
    logic              all_done;
    logic [LANES-1:0]  unused_lane_mask;

    lane_done_tracker #(
        .LANES     (LANES)
    ) u_tracker (
        .clk       (clk),
        .rst       (rst),
        .clr       (state == S_LOAD),
        .en        (state == S_CONV),
        .lane_done (lane_done),
        .mask      (unused_lane_mask),
        .all_done  (all_done)
    );

    // Next-state decode; start and pool_done only matter in IDLE and POOL.
    // NOTE: state_nx gets a default first so no path through the case infers a latch.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_LOAD;
            S_LOAD:  if (load_cnt == LOAD_LAST) state_nx = S_CONV;
            S_CONV: begin
                // Completion takes priority over a coincident timeout.
                if (all_done)                   state_nx = S_TREE;
                else if (conv_cnt == CONV_LAST) state_nx = S_IDLE;
            end
            S_TREE:  if (tree_cnt == TREE_LAST) state_nx = S_STORE;
            S_STORE: state_nx = S_POOL;
            S_POOL:  if (pool_done) state_nx = S_NEXT;
            S_NEXT:  state_nx = (out_c == CH_LAST) ? S_DONE : S_LOAD;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // State register and per-state cycle counters, each zeroed on state entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            load_cnt <= '0;
            tree_cnt <= '0;
            conv_cnt <= '0;
        end else begin
            state    <= state_nx;
            load_cnt <= (state == S_LOAD && state_nx == S_LOAD) ? load_cnt + LD_W'(1) : '0;
            tree_cnt <= (state == S_TREE && state_nx == S_TREE) ? tree_cnt + TR_W'(1) : '0;
            conv_cnt <= (state == S_CONV && state_nx == S_CONV) ? conv_cnt + TO_W'(1) : '0;
        end
    end

    // Channel index, sticky timeout flag and registered state-decoded strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_c       <= '0;
            timeout_err <= 1'b0;
            c_load      <= 1'b0;
            conv        <= 1'b0;
            tree        <= 1'b0;
            store       <= 1'b0;
            pool        <= 1'b0;
            busy        <= 1'b0;
            cout_done   <= 1'b0;
        end else begin
            if (state == S_NEXT && state_nx == S_LOAD) begin
                out_c <= out_c + CW'(1);
            end else if (state_nx == S_IDLE) begin
                out_c <= '0;
            end

            if (state == S_IDLE && start) begin
                timeout_err <= 1'b0;
            end else if (state == S_CONV && state_nx == S_IDLE) begin
                timeout_err <= 1'b1;
            end

            c_load    <= (state_nx == S_LOAD);
            conv      <= (state_nx == S_CONV);
            tree      <= (state_nx == S_TREE);
            store     <= (state_nx == S_STORE);
            pool      <= (state_nx == S_POOL);
            busy      <= (state_nx != S_IDLE);
            cout_done <= (state_nx == S_DONE);
        end
    end

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer: one instance with the default
// geometry and one with a short conv timeout and two channels.
module tb_layer_sequencer;

    localparam int OC   = 15;
    localparam int CW   = 4;
    localparam int OC_T = 2;

    logic          clk;
    logic          rst;

    logic          start, pool_done;
    logic [7:0]    lane_done;
    logic          c_load, conv, tree, store, pool, busy, cout_done, timeout_err;
    logic [CW-1:0] out_c;

    logic          start_t, pool_done_t;
    logic [7:0]    lane_done_t;
    logic          c_load_t, conv_t, tree_t, store_t, pool_t, busy_t, cout_done_t, timeout_err_t;
    logic [0:0]    out_c_t;

    int n_checks = 0;
    int n_fail   = 0;
    int store_cnt = 0;
    int done_cnt  = 0;
    int store_cnt_t = 0;

    layer_sequencer u_dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .lane_done   (lane_done),
        .pool_done   (pool_done),
        .c_load      (c_load),
        .conv        (conv),
        .tree        (tree),
        .store       (store),
        .pool        (pool),
        .out_c       (out_c),
        .busy        (busy),
        .cout_done   (cout_done),
        .timeout_err (timeout_err)
    );

    layer_sequencer #(
        .OC           (OC_T),
        .CONV_TIMEOUT (16)
    ) u_dut_to (
        .clk         (clk),
        .rst         (rst),
        .start       (start_t),
        .lane_done   (lane_done_t),
        .pool_done   (pool_done_t),
        .c_load      (c_load_t),
        .conv        (conv_t),
        .tree        (tree_t),
        .store       (store_t),
        .pool        (pool_t),
        .out_c       (out_c_t),
        .busy        (busy_t),
        .cout_done   (cout_done_t),
        .timeout_err (timeout_err_t)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled on the falling edge.
    always @(negedge clk) begin
        if (store)   store_cnt++;
        if (cout_done) done_cnt++;
        if (store_t) store_cnt_t++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one channel on u_dut starting from the first LOAD cycle.
    task automatic run_chan(input int ch, input int conv_wait, input int pool_wait,
                            input bit poke_start, input bit stop_at_pool);
        check("ld_c_load0", c_load, 1);
        check("ld_out_c", out_c, ch);
        check("ld_busy", busy, 1);
        if (poke_start) start = 1'b1;
        step();
        start = 1'b0;
        check("ld_c_load1", c_load, 1);
        step();
        check("conv_enter", {c_load, conv}, 2'b01);
        repeat (conv_wait) step();
        check("conv_hold", conv, 1);
        lane_done = 8'hFF;
        step();
        lane_done = 8'h00;
        check("tree_enter", {conv, tree}, 2'b01);
        step();
        step();
        check("tree_last", tree, 1);
        step();
        check("store_pulse", {tree, store}, 2'b01);
        step();
        check("pool_enter", {store, pool}, 2'b01);
        if (stop_at_pool) return;
        repeat (pool_wait) step();
        check("pool_hold", pool, 1);
        pool_done = 1'b1;
        step();
        pool_done = 1'b0;
        check("next_state", {pool, busy}, 2'b01);
        step();
        if (ch == OC - 1) check("done_pulse", {cout_done, out_c}, {1'b1, 4'(OC - 1)});
        else              check("next_load", {c_load, out_c}, {1'b1, 4'(ch + 1)});
    endtask

    initial begin
        int sc;
        bit seen;
        rst = 1'b1;
        start = 1'b0; lane_done = '0; pool_done = 1'b0;
        start_t = 1'b0; lane_done_t = '0; pool_done_t = 1'b0;
        step();
        step();
        check("rst_outputs", {c_load, conv, tree, store, pool, busy, cout_done, timeout_err}, 0);
        check("rst_out_c", out_c, 0);
        check("rst_outputs_t", {c_load_t, conv_t, busy_t, timeout_err_t}, 0);
        rst = 1'b0;
        step();
        check("idle_no_start", busy, 0);

        // Full run: lanes done 5 cycles into CONV, pool_done 2 cycles into POOL.
        store_cnt = 0; done_cnt = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int ch = 0; ch < OC; ch++) run_chan(ch, 5, 2, 1'b0, 1'b0);
        step();
        check("t1_idle", {busy, cout_done, out_c}, 0);
        check("t1_stores", store_cnt, 15);
        check("t1_done_cnt", done_cnt, 1);

        // Staggered single-cycle lane pulses: lane k at CONV cycle 3k.
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        for (int c = 0; c <= 21; c++) begin
            check("stag_conv", {conv, tree}, 2'b10);
            lane_done = (c % 3 == 0) ? 8'(1 << (c / 3)) : 8'h00;
            step();
            lane_done = 8'h00;
        end
        check("stag_tree", {conv, tree}, 2'b01);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();

        // All lanes on first CONV cycle; stray pool_done during TREE.
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check("ff_conv", conv, 1);
        lane_done = 8'hFF;
        step();
        lane_done = 8'h00;
        check("ff_conv_1cyc", {conv, tree}, 2'b01);
        pool_done = 1'b1;
        step();
        pool_done = 1'b0;
        check("ff_tree1_ignore_pd", {tree, pool, store}, 3'b100);
        step();
        check("ff_tree2", tree, 1);
        step();
        check("ff_store", {tree, store}, 2'b01);
        sc = store_cnt;
        step();
        check("ff_pool0", {store, pool}, 2'b01);
        pool_done = 1'b1;
        step();
        pool_done = 1'b0;
        check("ff_pool_1cyc", {pool, busy}, 2'b01);
        check("ff_one_store", store_cnt, sc + 1);
        step();
        check("ff_next_load", {c_load, out_c}, {1'b1, 4'd1});
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();

        // Timeout on the short-timeout instance: lane 3 never finishes.
        start_t = 1'b1;
        step();
        start_t = 1'b0;
        step();
        step();
        lane_done_t = 8'hF7;
        for (int c = 0; c < 16; c++) begin
            check("to_conv", conv_t, 1);
            step();
        end
        check("to_idle", {conv_t, busy_t, tree_t}, 0);
        check("to_err", timeout_err_t, 1);
        check("to_out_c", out_c_t, 0);
        check("to_no_store", store_cnt_t, 0);
        step();
        check("to_err_sticky", timeout_err_t, 1);
        start_t = 1'b1;
        lane_done_t = 8'hFF;
        pool_done_t = 1'b1;
        step();
        start_t = 1'b0;
        check("to_restart", {c_load_t, timeout_err_t}, 2'b10);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (cout_done_t) seen = 1'b1;
            else step();
        end
        check("to_rerun_done", seen, 1);
        check("to_rerun_stores", store_cnt_t, 2);
        check("to_rerun_err", timeout_err_t, 0);
        lane_done_t = 8'h00;
        pool_done_t = 1'b0;
        step();

        // Reset during POOL of channel 7, then a stray start during LOAD.
        store_cnt = 0; done_cnt = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int ch = 0; ch < 7; ch++) run_chan(ch, 0, 0, 1'b0, 1'b0);
        run_chan(7, 0, 0, 1'b0, 1'b1);
        check("rp_stores_before", store_cnt, 8);
        sc = store_cnt;
        rst = 1'b1;
        step();
        check("rp_outputs", {c_load, conv, tree, store, pool, busy, cout_done, timeout_err}, 0);
        check("rp_out_c", out_c, 0);
        rst = 1'b0;
        step();
        step();
        check("rp_no_store", store_cnt, sc);
        check("rp_no_done", {done_cnt[0], busy}, 0);
        store_cnt = 0; done_cnt = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int ch = 0; ch < OC; ch++) run_chan(ch, ch % 4, ch % 3, ch == 0, 1'b0);
        step();
        check("rp_idle", {busy, cout_done, out_c}, 0);
        check("rp_stores", store_cnt, 15);
        check("rp_done_cnt", done_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
